fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch PC register and sequences instruction fetch for the 5-stage MIPS pipeline.
- Resolves next-PC selection from ID/EX redirect requests (jr > j > branch > stall > sequential) and drives a valid/ack handshake to instruction memory.
- Buffers one fetched word across an ID stall and presents the IF/ID payload.
- Kills wrong-path fetches on a redirect, including a fetch still in flight.

Parameters:
- RESET_PC, 32'h0000_3000, byte address of the first fetch; bits [1:0] ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  ID cannot accept a new instruction this cycle
- br_i  in  1  branch taken (resolved in ID)
- br_off_i  in  16  signed word offset for the branch
- j_i  in  1  j/jal decoded
- j_idx_i  in  26  jump index
- jr_i  in  1  jr/jalr resolved
- jr_tgt_i  in  32  register jump target, byte address
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  30  word address [31:2]
- imem_ack_i  in  1  imem returns data this cycle
- imem_rdata_i  in  32  instruction word
- if_valid_o  out  1  IF/ID payload valid
- if_pc_o  out  30  word PC of the payload
- if_instr_o  out  32  instruction payload
- redir_cnt_o  out  16  redirect counter (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC[31:2]; state BOOT.
  - if_valid_o=0, if_pc_o=0, if_instr_o=0, imem_req_o=0.
  - Skid buffer empty; redir_cnt_o=0.
- Reset mid-fetch abandons the request; imem must tolerate the abandoned request.
- Redirect target, computed with 30-bit wrap:
  - jr: jr_tgt_i[31:2].
  - j: {pc[31:28], j_idx_i}.
  - branch: pc + sign_extend(br_off_i) to 30 bits; base is the current fetch pc register.
- Redirect priority is jr > j > branch. Any redirect overrides stall_i.
- States:
  - BOOT: one cycle, no request; then FETCH.
  - FETCH: imem_req_o=1, imem_addr_o=pc. imem_addr_o must stay stable while req=1 and ack=0.
  - DISCARD: req held at the old address until ack; the returned data is dropped; then FETCH at the new pc.
  - FULL: skid buffer holds a word; req=0.
- In FETCH with ack=1 and no redirect:
  - If stall_i=0 and the buffer is empty: if_* <= {1, pc, rdata}; pc <= pc+1.
  - If stall_i=1: the word goes to the skid buffer; pc <= pc+1; go to FULL. if_* hold.
- FULL with stall_i=0: buffer moves to if_*; buffer empties; go to FETCH. There is exactly one bubble-free handoff.
- stall_i=1 with no ack: if_* hold; request continues.
- stall_i=0, no ack, no redirect: if_valid_o <= 0.
- Redirect in any cycle:
  - Next edge: if_valid_o <= 0 (flush), buffer cleared, pc <= target.
  - If req=1 and ack=0 that cycle, go to DISCARD; else go to FETCH.
  - Ack in the same cycle as the redirect: data dropped; go to FETCH.
- Redirect while in DISCARD: pc is updated again (latest wins); stay in DISCARD.
- PC increment wraps 30'h3FFF_FFFF -> 0.

Optional Feature:
- FETCH_PERF_EN:
  - Defined: redir_cnt_o counts edges at which a redirect is accepted; it saturates at 16'hFFFF.
  - Undefined: no counter logic; redir_cnt_o is tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - state encoding (BOOT, FETCH, DISCARD, FULL, 2 bits);
  - the RESET_PC default;
  - function next_target(pc, br, off, j, idx, jr, tgt) shared with the existing next-PC logic.
- One sub-module, fetch_skid_buf: 1-entry {pc, instr} buffer with load/unload/clear.

Test Plan:
- Reset release, ack every cycle, no stalls -> imem_addr_o 0xC00, 0xC01, 0xC02 on successive cycles; if_pc_o trails by one cycle with if_valid_o=1.
- stall_i=1 for 3 cycles while ack arrives for pc 0xC02 -> req drops (FULL); if_* hold at 0xC01; on release if_pc_o=0xC02, then next fetch at 0xC03.
- br_i=1, br_off_i=16'hFFFC at pc 0xC05 -> next edge if_valid_o=0, imem_addr_o=0xC01.
- jr_i and j_i together, jr_tgt_i=0x0000_3040 -> jr wins; imem_addr_o=0xC10.
- j_i during an un-acked fetch at 0xC07 (ack two cycles later), j_idx_i=0x100 -> DISCARD: addr stays 0xC07 until ack; data dropped; then fetch at 0x0000100.
- rst_n pulsed low mid-DISCARD -> all outputs reset immediately; BOOT; first fetch at 0xC00. With FETCH_PERF_EN, 3 redirects -> redir_cnt_o=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and next-PC helper for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        FULL    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Redirect target on a word PC with 30-bit wrap; priority jr > j > branch.
    function automatic logic [29:0] next_target(
        input logic [29:0] pc,
        input logic        br,
        input logic [15:0] off,
        input logic        j,
        input logic [25:0] idx,
        input logic        jr,
        input logic [29:0] tgt
    );
        logic [29:0] t;
        t = pc;
        if (jr)
            t = tgt;
        else if (j)
            t = {pc[29:26], idx};
        else if (br)
            t = pc + {{14{off[15]}}, off};
        return t;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer used while ID is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [29:0] wr_pc,
    input  logic [31:0] wr_instr,
    output logic        full,
    output logic [29:0] buf_pc,
    output logic [31:0] buf_instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            buf_pc    <= wr_pc;
            buf_instr <= wr_instr;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and imem handshake sequencer for the 5-stage MIPS pipeline.
// Build option: define FETCH_PERF_EN to enable the saturating redirect counter.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_i,
    input  logic [15:0] br_off_i,
    input  logic        j_i,
    input  logic [25:0] j_idx_i,
    input  logic        jr_i,
    input  logic [31:0] jr_tgt_i,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [29:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [15:0] redir_cnt_o
);

    fetch_state_t state, state_nxt;
    logic [29:0]  pc, pc_nxt;
    logic [29:0]  discard_addr, discard_nxt;
    logic         valid_nxt;
    logic [29:0]  if_pc_nxt;
    logic [31:0]  if_instr_nxt;
    logic         redirect;
    logic [29:0]  target;
    logic         buf_load, buf_unload, buf_clear, buf_full;
    logic [29:0]  buf_pc;
    logic [31:0]  buf_instr;
    logic         unused_tgt_bits;

    assign unused_tgt_bits = ^jr_tgt_i[1:0];

    assign redirect    = jr_i | j_i | br_i;
    assign target      = next_target(pc, br_i, br_off_i, j_i, j_idx_i, jr_i, jr_tgt_i[31:2]);
    assign imem_req_o  = (state == FETCH) || (state == DISCARD);
    // A killed fetch keeps presenting its original address until imem acks it.
    assign imem_addr_o = (state == DISCARD) ? discard_addr : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC[31:2];
            discard_addr <= '0;
            if_valid_o   <= 1'b0;
            if_pc_o      <= '0;
            if_instr_o   <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            discard_addr <= discard_nxt;
            if_valid_o   <= valid_nxt;
            if_pc_o      <= if_pc_nxt;
            if_instr_o   <= if_instr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        discard_nxt  = discard_addr;
        valid_nxt    = if_valid_o;
        if_pc_nxt    = if_pc_o;
        if_instr_nxt = if_instr_o;
        buf_load     = 1'b0;
        buf_unload   = 1'b0;
        buf_clear    = 1'b0;
        if (redirect) begin
            valid_nxt = 1'b0;
            buf_clear = 1'b1;
            pc_nxt    = target;
            if (imem_req_o && !imem_ack_i) begin
                state_nxt = DISCARD;
                if (state == FETCH)
                    discard_nxt = pc;
            end else begin
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                BOOT: state_nxt = FETCH;
                FETCH: begin
                    if (imem_ack_i) begin
                        pc_nxt = pc + 30'd1;
                        if (stall_i) begin
                            buf_load  = 1'b1;
                            state_nxt = FULL;
                        end else begin
                            valid_nxt    = 1'b1;
                            if_pc_nxt    = pc;
                            if_instr_nxt = imem_rdata_i;
                        end
                    end else if (!stall_i) begin
                        valid_nxt = 1'b0;
                    end
                end
                DISCARD: begin
                    if (imem_ack_i)
                        state_nxt = FETCH;
                end
                FULL: begin
                    if (!stall_i && buf_full) begin
                        valid_nxt    = 1'b1;
                        if_pc_nxt    = buf_pc;
                        if_instr_nxt = buf_instr;
                        buf_unload   = 1'b1;
                        state_nxt    = FETCH;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .unload    (buf_unload),
        .clear     (buf_clear),
        .wr_pc     (pc),
        .wr_instr  (imem_rdata_i),
        .full      (buf_full),
        .buf_pc    (buf_pc),
        .buf_instr (buf_instr)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] redir_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            redir_cnt <= '0;
        else if (redirect && (redir_cnt != 16'hFFFF))
            redir_cnt <= redir_cnt + 16'd1;
    end

    assign redir_cnt_o = redir_cnt;
`else
    assign redir_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand sequences, random vs model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, br_i, j_i, jr_i, imem_ack_i;
    logic [15:0] br_off_i;
    logic [25:0] j_idx_i;
    logic [31:0] jr_tgt_i, imem_rdata_i;
    logic        imem_req_o, if_valid_o;
    logic [29:0] imem_addr_o, if_pc_o;
    logic [31:0] if_instr_o;
    logic [15:0] redir_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .br_i         (br_i),
        .br_off_i     (br_off_i),
        .j_i          (j_i),
        .j_idx_i      (j_idx_i),
        .jr_i         (jr_i),
        .jr_tgt_i     (jr_tgt_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .redir_cnt_o  (redir_cnt_o)
    );

    typedef struct {
        bit          stall;
        bit          br;
        logic [15:0] off;
        bit          j;
        logic [25:0] idx;
        bit          jr;
        logic [31:0] tgt;
        bit          ack;
        logic [31:0] rdata;
        bit          e_req;
        logic [29:0] e_addr;
        bit          e_valid;
        logic [29:0] e_pc;
        logic [31:0] e_instr;
        int          e_cnt;
    } vec_t;

    // Reference model: fetch progress expressed as pc, a kill marker and a held-word queue.
    logic [29:0] m_pc;
    bit          m_boot;
    bit          m_killing;
    logic [29:0] m_kill_addr;
    logic [61:0] m_held[$];
    bit          m_valid;
    logic [29:0] m_ifpc;
    logic [31:0] m_instr;
    int          m_cnt;

    function automatic bit m_req();
        return !m_boot && (m_held.size() == 0);
    endfunction

    function automatic logic [29:0] m_addr();
        return m_killing ? m_kill_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_pc      = 30'h0C00;
        m_boot    = 1'b1;
        m_killing = 1'b0;
        m_kill_addr = '0;
        m_held.delete();
        m_valid   = 1'b0;
        m_ifpc    = '0;
        m_instr   = '0;
        m_cnt     = 0;
    endtask

    task automatic model_step(input bit stall, input bit br, input logic [15:0] off,
                              input bit j, input logic [25:0] idx, input bit jr,
                              input logic [31:0] tgt, input bit ack, input logic [31:0] rdata);
        bit          req_now;
        logic [29:0] addr_now;
        logic [29:0] dest;
        int          soff;
        req_now  = m_req();
        addr_now = m_addr();
        if (br || j || jr) begin
            soff = int'(signed'(off));
            if (jr)
                dest = 30'(tgt >> 2);
            else if (j)
                dest = (m_pc & 30'h3C00_0000) | 30'(idx);
            else
                dest = 30'(int'(m_pc) + soff);
            m_valid = 1'b0;
            m_held.delete();
            if (req_now && !ack) begin
                m_killing   = 1'b1;
                m_kill_addr = addr_now;
            end else begin
                m_killing = 1'b0;
            end
            m_pc   = dest;
            m_boot = 1'b0;
            if (m_cnt < 65535)
                m_cnt++;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_killing) begin
            if (ack)
                m_killing = 1'b0;
        end else if (m_held.size() != 0) begin
            if (!stall) begin
                m_valid = 1'b1;
                m_ifpc  = m_held[0][61:32];
                m_instr = m_held[0][31:0];
                m_held.delete();
            end
        end else if (ack) begin
            if (stall) begin
                m_held.push_back({m_pc, rdata});
            end else begin
                m_valid = 1'b1;
                m_ifpc  = m_pc;
                m_instr = rdata;
            end
            m_pc = m_pc + 30'd1;
        end else if (!stall) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_field(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_output(input string tag, input bit e_req, input logic [29:0] e_addr,
                                input bit e_valid, input logic [29:0] e_pc,
                                input logic [31:0] e_instr, input int e_cnt);
        check_field({tag, " req"}, 32'(imem_req_o), 32'(e_req));
        if (e_req)
            check_field({tag, " addr"}, 32'(imem_addr_o), 32'(e_addr));
        check_field({tag, " valid"}, 32'(if_valid_o), 32'(e_valid));
        if (e_valid) begin
            check_field({tag, " if_pc"}, 32'(if_pc_o), 32'(e_pc));
            check_field({tag, " if_instr"}, if_instr_o, e_instr);
        end
`ifdef FETCH_PERF_EN
        check_field({tag, " cnt"}, 32'(redir_cnt_o), 32'(e_cnt));
`else
        check_field({tag, " cnt"}, 32'(redir_cnt_o), 32'(e_cnt * 0));
`endif
    endtask

    task automatic apply_stimulus(input bit stall, input bit br, input logic [15:0] off,
                                  input bit j, input logic [25:0] idx, input bit jr,
                                  input logic [31:0] tgt, input bit ack, input logic [31:0] rdata);
        stall_i      = stall;
        br_i         = br;
        br_off_i     = off;
        j_i          = j;
        j_idx_i      = idx;
        jr_i         = jr;
        jr_tgt_i     = tgt;
        imem_ack_i   = ack;
        imem_rdata_i = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_field({tag, " req"}, 32'(imem_req_o), 32'd0);
        check_field({tag, " valid"}, 32'(if_valid_o), 32'd0);
        check_field({tag, " if_pc"}, 32'(if_pc_o), 32'd0);
        check_field({tag, " if_instr"}, if_instr_o, 32'd0);
        check_field({tag, " cnt"}, 32'(redir_cnt_o), 32'd0);
    endtask

    vec_t vecs[17];

    initial begin
        bit          r_stall, r_br, r_j, r_jr, r_ack;
        logic [15:0] r_off;
        logic [25:0] r_idx;
        logic [31:0] r_tgt, r_rdata;

        //           stall br off       j  idx      jr tgt           ack rdata          req addr     v  pc       instr          cnt
        vecs[0]  = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        0, 32'h0,          1, 30'hC00, 0, 30'h0,   32'h0,         0};
        vecs[1]  = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0000,  1, 30'hC01, 1, 30'hC00, 32'hA000_0000, 0};
        vecs[2]  = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0001,  1, 30'hC02, 1, 30'hC01, 32'hA000_0001, 0};
        vecs[3]  = '{1, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0002,  0, 30'h0,   1, 30'hC01, 32'hA000_0001, 0};
        vecs[4]  = '{1, 0, 16'h0,    0, 26'h0,   0, 32'h0,        0, 32'h0,          0, 30'h0,   1, 30'hC01, 32'hA000_0001, 0};
        vecs[5]  = '{1, 0, 16'h0,    0, 26'h0,   0, 32'h0,        0, 32'h0,          0, 30'h0,   1, 30'hC01, 32'hA000_0001, 0};
        vecs[6]  = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        0, 32'h0,          1, 30'hC03, 1, 30'hC02, 32'hA000_0002, 0};
        vecs[7]  = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0003,  1, 30'hC04, 1, 30'hC03, 32'hA000_0003, 0};
        vecs[8]  = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0004,  1, 30'hC05, 1, 30'hC04, 32'hA000_0004, 0};
        vecs[9]  = '{0, 1, 16'hFFFC, 0, 26'h0,   0, 32'h0,        1, 32'hDEAD_0001,  1, 30'hC01, 0, 30'h0,   32'h0,         1};
        vecs[10] = '{0, 0, 16'h0,    1, 26'h3FF, 1, 32'h0000_3040, 1, 32'hDEAD_0002, 1, 30'hC10, 0, 30'h0,   32'h0,         2};
        vecs[11] = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0005,  1, 30'hC11, 1, 30'hC10, 32'hA000_0005, 2};
        vecs[12] = '{0, 0, 16'h0,    0, 26'h0,   1, 32'h0000_301C, 1, 32'hDEAD_0003, 1, 30'hC07, 0, 30'h0,   32'h0,         3};
        vecs[13] = '{0, 0, 16'h0,    1, 26'h100, 0, 32'h0,        0, 32'h0,          1, 30'hC07, 0, 30'h0,   32'h0,         4};
        vecs[14] = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        0, 32'h0,          1, 30'hC07, 0, 30'h0,   32'h0,         4};
        vecs[15] = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hDEAD_0004,  1, 30'h100, 0, 30'h0,   32'h0,         4};
        vecs[16] = '{0, 0, 16'h0,    0, 26'h0,   0, 32'h0,        1, 32'hA000_0006,  1, 30'h101, 1, 30'h100, 32'hA000_0006, 4};

        rst_n = 1'b0;
        stall_i = 0; br_i = 0; j_i = 0; jr_i = 0; imem_ack_i = 0;
        br_off_i = '0; j_idx_i = '0; jr_tgt_i = '0; imem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].stall, vecs[i].br, vecs[i].off, vecs[i].j, vecs[i].idx,
                           vecs[i].jr, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
            check_output($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                         vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_cnt);
        end

        // Enter DISCARD, then pulse reset mid-cycle and confirm an immediate return to reset values.
        apply_stimulus(0, 0, 16'h0, 1, 26'h200, 0, 32'h0, 0, 32'h0);
        check_output("discard", 1, 30'h101, 0, 30'h0, 32'h0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 32'h0);
        check_output("boot", 1, 30'hC00, 0, 30'h0, 32'h0, 0);
        apply_stimulus(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 32'hA000_0007);
        check_output("first", 1, 30'hC01, 1, 30'hC00, 32'hA000_0007, 0);

        // PC increment wrap at the top of the 30-bit word space.
        apply_stimulus(0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 1, 32'hDEAD_0005);
        check_output("wrap_tgt", 1, 30'h3FFF_FFFF, 0, 30'h0, 32'h0, 1);
        apply_stimulus(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 32'hA000_0008);
        check_output("wrap_inc", 1, 30'h0, 1, 30'h3FFF_FFFF, 32'hA000_0008, 1);

        // Randomized run against the reference model.
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r_stall = ($urandom % 3) == 0;
            r_br    = ($urandom % 10) == 0;
            r_j     = ($urandom % 14) == 0;
            r_jr    = ($urandom % 14) == 0;
            r_off   = 16'($urandom);
            r_idx   = 26'($urandom);
            r_tgt   = $urandom;
            r_rdata = $urandom;
            r_ack   = m_req() && (($urandom % 2) == 0);
            apply_stimulus(r_stall, r_br, r_off, r_j, r_idx, r_jr, r_tgt, r_ack, r_rdata);
            model_step(r_stall, r_br, r_off, r_j, r_idx, r_jr, r_tgt, r_ack, r_rdata);
            check_output("rand", m_req(), m_addr(), m_valid, m_ifpc, m_instr, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
